uart_rx_fifo: RTL and testbench

Parametrised UART receiver with a buffered output. It oversamples the serial line with a programmable bit period and supports 5-9 data bits with none, odd or even parity. Each received word is stored, together with its parity and framing status, in an internal first-word-fall-through FIFO. It sits between the board RX pin and the command decoder, and replaces the single-word, fixed-format receiver that required a one-clock-per-bit line.

---
 rtl/uart_rx_fifo.sv | 234 +++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver (5-9 data bits, none/odd/even parity) feeding a
// first-word-fall-through FIFO that stores each word with its parity and framing flags.
// Optional build macro: UART_RX_SYNC_EN adds a 2-flop input synchronizer on rx.
module uart_rx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 2,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    input  logic                          rd_ready,
    input  logic                          err_clr,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_perr,
    output logic                          rd_ferr,
    output logic                          rd_valid,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overrun,
    output logic                          busy
);

    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = AW + 1;
    localparam int unsigned CW    = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned BCW   = $clog2(DATA_BITS);
    localparam int unsigned WordW = DATA_BITS + 2;
    localparam int unsigned Half  = CLKS_PER_BIT / 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitHigh
    } state_e;

    logic rx_s;

`ifdef UART_RX_SYNC_EN
    logic sync1_q, sync2_q;

    // Two-flop synchronizer; resets to the idle line level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;
`else
    assign rx_s = rx;
`endif

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BCW-1:0]       bit_q, bit_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 perr_q, perr_d;
    logic                 push;
    logic [WordW-1:0]     push_word;
    logic                 expire;

    assign expire = (cnt_q == CW'(1));

    // Receiver state, bit timer, shift register and parity result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
        end
    end

    // Frame sequencing: each bit is sampled when the timer reaches 1, then reloaded.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        data_d    = data_q;
        perr_d    = perr_q;
        push      = 1'b0;
        push_word = {~rx_s, perr_q, data_q};
        unique case (state_q)
            StIdle: begin
                if (!rx_s) begin
                    cnt_d   = CW'(Half);
                    bit_d   = '0;
                    perr_d  = 1'b0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (expire) begin
                    if (rx_s) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d   = CW'(CLKS_PER_BIT);
                        state_d = StData;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StData: begin
                if (expire) begin
                    data_d = {rx_s, data_q[DATA_BITS-1:1]};
                    cnt_d  = CW'(CLKS_PER_BIT);
                    bit_d  = bit_q + BCW'(1);
                    if (bit_q == BCW'(DATA_BITS - 1)) begin
                        state_d = (PARITY != 0) ? StParity : StStop;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StParity: begin
                if (expire) begin
                    cnt_d   = CW'(CLKS_PER_BIT);
                    perr_d  = (PARITY == 2) ? ((^data_q) != rx_s) : ((~^data_q) != rx_s);
                    state_d = StStop;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StStop: begin
                if (expire) begin
                    push    = 1'b1;
                    // A low stop bit may be a break; hold off until the line idles again.
                    state_d = rx_s ? StIdle : StWaitHigh;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StWaitHigh: begin
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy = (state_q != StIdle);

    // ---------------- FIFO ----------------
    logic [WordW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             overrun_q, overrun_d;
    logic             pop_ok, push_ok, drop;
    logic             full_w, empty_w;

    assign full_w  = (count_q == CntW'(FIFO_DEPTH));
    assign empty_w = (count_q == '0);
    assign pop_ok  = rd_ready & ~empty_w;
    // A push into a full FIFO is still accepted if a pop frees a slot on the same edge.
    assign push_ok = push & (~full_w | pop_ok);
    assign drop    = push & full_w & ~pop_ok;

    // Pointer, occupancy and sticky-overrun next state.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        if (err_clr) begin
            overrun_d = 1'b0;
        end
        if (drop) begin
            overrun_d = 1'b1;
        end
    end

    // FIFO control registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage array; contents are don't-care while empty since the outputs are gated.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    logic [WordW-1:0] head;
    assign head     = mem_q[rd_ptr_q];
    assign rd_valid = ~empty_w;
    assign rd_data  = rd_valid ? head[DATA_BITS-1:0] : '0;
    assign rd_perr  = rd_valid & head[DATA_BITS];
    assign rd_ferr  = rd_valid & head[DATA_BITS+1];
    assign full     = full_w;
    assign count    = count_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (16 clocks/bit, 8 data bits, even parity, depth 4).
module tb_uart_rx_fifo;

    localparam int CPB = 16;
    localparam int H   = CPB / 2;
`ifdef UART_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    // Stop sample offset from t0: H + (8 data + 1 parity + 1) bits.
    localparam int STOP_OFS = H + 10 * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rd_ready = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rd_data;
    logic       rd_perr, rd_ferr, rd_valid, full, overrun, busy;
    logic [2:0] count;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [9:0] sb[$];

    uart_rx_fifo #(
        .CLKS_PER_BIT(16),
        .DATA_BITS   (8),
        .PARITY      (2),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (rx),
        .rd_ready(rd_ready),
        .err_clr (err_clr),
        .rd_data (rd_data),
        .rd_perr (rd_perr),
        .rd_ferr (rd_ferr),
        .rd_valid(rd_valid),
        .full    (full),
        .count   (count),
        .overrun (overrun),
        .busy    (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit expired, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Drives one frame starting at the current negedge; rx is left at the stop-bit level.
    task automatic send_frame(input logic [7:0] d, input logic pb, input logic stop_b);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
        rx = pb;
        repeat (CPB) @(negedge clk);
        rx = stop_b;
        repeat (CPB) @(negedge clk);
    endtask

    // One read handshake; returns what was presented at the head.
    task automatic pop_word(output logic v, output logic [9:0] w);
        @(negedge clk);
        v = rd_valid;
        w = {rd_ferr, rd_perr, rd_data};
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
        total++; if (rd_perr !== 1'b0) begin bad++; $display("FAIL reset_rd_perr got=%b exp=0", rd_perr); end
        total++; if (rd_ferr !== 1'b0) begin bad++; $display("FAIL reset_rd_ferr got=%b exp=0", rd_ferr); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic;
        int pin;
        logic v;
        logic [9:0] w, e;
        sb.push_back({2'b00, 8'hA5});
        @(negedge clk);
        pin = cyc + 1;
        fork
            send_frame(8'hA5, 1'b0, 1'b1);
            begin
                wait (cyc == pin + LAT - 1); #1;
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_pre got=%b exp=0", busy); end
                wait (cyc == pin + LAT); #1;
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_t0 got=%b exp=1", busy); end
                wait (cyc == pin + LAT + STOP_OFS - 1); #1;
                total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_early got=%b exp=0", rd_valid); end
                wait (cyc == pin + LAT + STOP_OFS); #1;
                total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", rd_valid); end
                total++; if (count !== 3'd1) begin bad++; $display("FAIL basic_count got=%0d exp=1", count); end
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b exp=0", busy); end
            end
        join
        pop_word(v, w);
        e = sb.pop_front();
        total++; if (v !== 1'b1 || w !== e) begin bad++; $display("FAIL basic_word got=%b/%h exp=1/%h", v, w, e); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL basic_count_after got=%0d exp=0", count); end
    endtask

    task automatic test_parity_err;
        logic v;
        logic [9:0] w, e;
        sb.push_back({2'b01, 8'h3C});
        @(negedge clk);
        send_frame(8'h3C, 1'b1, 1'b1);
        pop_word(v, w);
        e = sb.pop_front();
        total++; if (v !== 1'b1 || w !== e) begin bad++; $display("FAIL perr_word got=%b/%h exp=1/%h", v, w, e); end
    endtask

    task automatic test_break;
        logic v;
        logic [9:0] w, e;
        sb.push_back({2'b10, 8'h00});
        @(negedge clk);
        send_frame(8'h00, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL break_busy_low got=%b exp=1", busy); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL break_count_low got=%0d exp=1", count); end
        rx = 1'b1;
        repeat (LAT + 2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL break_busy_high got=%b exp=0", busy); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL break_count got=%0d exp=1", count); end
        pop_word(v, w);
        e = sb.pop_front();
        total++; if (v !== 1'b1 || w !== e) begin bad++; $display("FAIL break_word got=%b/%h exp=1/%h", v, w, e); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL break_empty got=%b exp=0", rd_valid); end
    endtask

    task automatic test_glitch;
        int pin;
        @(negedge clk);
        pin = cyc + 1;
        rx = 1'b0;
        repeat (7) @(negedge clk);
        rx = 1'b1;
        wait (cyc == pin + LAT + H - 1); #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch_busy got=%b exp=1", busy); end
        wait (cyc == pin + LAT + H); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_idle got=%b exp=0", busy); end
        repeat (5) @(negedge clk);
        total++; if (count !== 3'd0) begin bad++; $display("FAIL glitch_count got=%0d exp=0", count); end
    endtask

    task automatic test_overrun;
        logic v;
        logic [9:0] w, e;
        logic [7:0] d;
        @(negedge clk);
        for (int i = 1; i <= 5; i++) begin
            d = 8'(i);
            if (i <= 4) sb.push_back({2'b00, d});
            send_frame(d, ^d, 1'b1);
        end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL ovr_full got=%b exp=1", full); end
        total++; if (count !== 3'd4) begin bad++; $display("FAIL ovr_count got=%0d exp=4", count); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
        for (int i = 0; i < 4; i++) begin
            pop_word(v, w);
            e = sb.pop_front();
            total++; if (v !== 1'b1 || w !== e) begin bad++; $display("FAIL ovr_word%0d got=%b/%h exp=1/%h", i, v, w, e); end
        end
        pop_word(v, w);
        total++; if (v !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL ovr_empty_pop got=%b/%0d exp=0/0", v, count); end
    endtask

    task automatic test_full_pop;
        int pin;
        logic v;
        logic [9:0] w, e;
        logic [7:0] d;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            d = 8'h11 + 8'(i);
            sb.push_back({2'b00, d});
            send_frame(d, ^d, 1'b1);
        end
        pin = cyc + 1;
        fork
            send_frame(8'h06, 1'b0, 1'b1);
            begin
                wait (cyc == pin + LAT + STOP_OFS - 1);
                @(negedge clk);
                w = {rd_ferr, rd_perr, rd_data};
                rd_ready = 1'b1;
                @(negedge clk);
                rd_ready = 1'b0;
                e = sb.pop_front();
                total++; if (w !== e) begin bad++; $display("FAIL fullpop_head got=%h exp=%h", w, e); end
            end
        join
        sb.push_back({2'b00, 8'h06});
        total++; if (count !== 3'd4) begin bad++; $display("FAIL fullpop_count got=%0d exp=4", count); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL fullpop_overrun got=%b exp=0", overrun); end
        for (int i = 0; i < 4; i++) begin
            pop_word(v, w);
            e = sb.pop_front();
            total++; if (v !== 1'b1 || w !== e) begin bad++; $display("FAIL fullpop_word%0d got=%b/%h exp=1/%h", i, v, w, e); end
        end
    endtask

    task automatic test_reset_mid;
        logic v;
        logic [9:0] w, e;
        @(negedge clk);
        send_frame(8'h81, 1'b0, 1'b1);
        rx = 1'b0;
        repeat (60) @(negedge clk);
        total++; if (busy !== 1'b1 || rd_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%b/%b exp=1/1", busy, rd_valid); end
        rst_n = 1'b0;
        @(negedge clk);
        total++; if ({rd_data, rd_perr, rd_ferr, rd_valid, full, count, overrun, busy} !== 16'h0000) begin
            bad++;
            $display("FAIL rstmid_outputs got=%h/%b%b%b%b/%0d/%b%b exp=all 0", rd_data, rd_perr, rd_ferr,
                     rd_valid, full, count, overrun, busy);
        end
        rst_n = 1'b1;
        rx = 1'b1;
        sb.delete();
        repeat (40) @(negedge clk);
        sb.push_back({2'b00, 8'h5A});
        send_frame(8'h5A, 1'b0, 1'b1);
        total++; if (count !== 3'd1) begin bad++; $display("FAIL rstmid_count got=%0d exp=1", count); end
        pop_word(v, w);
        e = sb.pop_front();
        total++; if (v !== 1'b1 || w !== e) begin bad++; $display("FAIL rstmid_word got=%b/%h exp=1/%h", v, w, e); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity_err();
        test_break();
        test_glitch();
        test_overrun();
        test_full_pop();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
